// File: rtl/pc_watch_pkg.sv
// Shared types and constants for the PC watch unit.
// Also supplies the default address width macro ADDR_SIZE when the build
// does not define it.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

package pc_watch_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_BP    = 2'd1;
   localparam logic [1:0] CAUSE_STALL = 2'd2;

endpackage

// File: rtl/pc_trace_buf.sv
// Overwriting circular buffer of retired PCs.
// A push into a full buffer drops the oldest entry, so the count saturates
// at DEPTH. rd_data shows the oldest entry combinationally (0 when empty).
// Pop interface: pop is a request taken only when empty is low; a pop while
// empty is ignored; push and pop may coincide in any cycle.
module pc_trace_buf #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8,
   localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic [CW-1:0]         count
);

   localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);
   localparam logic [CW-1:0] CW_ONE  = CW'(1);
   localparam logic [PW-1:0] PW_ONE  = PW'(1);

   logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full;
   logic                  do_pop;

   // Pointer/count update; a push into a full buffer advances the read side too
   always_comb begin
      full     = (count_q == DEPTH_V);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW_ONE;
      end
      if (do_pop || (push && full)) begin
         rd_ptr_d = rd_ptr_q + PW_ONE;
      end
      if (push && !do_pop && !full) begin
         count_d = count_q + CW_ONE;
      end else if (!push && do_pop) begin
         count_d = count_q - CW_ONE;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, no reset needed: the count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pc_watch_unit.sv
// PC watch unit: breakpoint comparators, stall detector, cycle/retire
// counters and an optional retired-PC trace buffer.
// Build option: define PC_TRACE_EN to include the trace buffer; without it
// the trace port reads as permanently empty.
// dbg_state exposes the RUN/HALTED state register.
module pc_watch_unit
   import pc_watch_pkg::*;
#(
   parameter int ADDR_WIDTH  = `ADDR_SIZE,
   parameter int NUM_BP      = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int STALL_LIMIT = 16,
   parameter int TRACE_DEPTH = 8,
   localparam int BP_IW      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
   localparam int TC_W       = $clog2(TRACE_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wb_valid,
   input  logic [ADDR_WIDTH-1:0] pc_wb,
   input  logic                  bp_we,
   input  logic [BP_IW-1:0]      bp_idx,
   input  logic [ADDR_WIDTH-1:0] bp_addr,
   input  logic                  bp_arm,
   input  logic                  clear,
   output logic                  halt,
   output logic [1:0]            halt_cause,
   output logic [BP_IW-1:0]      hit_idx,
   output logic [CNT_WIDTH-1:0]  cycle_cnt,
   output logic [CNT_WIDTH-1:0]  retire_cnt,
   input  logic                  trc_rd,
   output logic [ADDR_WIDTH-1:0] trc_data,
   output logic                  trc_empty,
   output logic [TC_W-1:0]       trc_count,
   output logic                  dbg_state
);

   localparam int SC_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [SC_W-1:0]      SC_ONE   = SC_W'(1);
   localparam logic [SC_W-1:0]      SC_LIMIT = SC_W'(STALL_LIMIT);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] bp_addr_q [NUM_BP];
   logic [ADDR_WIDTH-1:0] bp_addr_d [NUM_BP];
   logic [NUM_BP-1:0]     bp_arm_q, bp_arm_d;
   logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0]  retire_q, retire_d;
   logic [SC_W-1:0]       stall_q, stall_d;
   logic [1:0]            cause_q, cause_d;
   logic [BP_IW-1:0]      hit_idx_q, hit_idx_d;
   logic                  hit;
   logic [BP_IW-1:0]      hit_sel;
   logic                  run_retire;

   // Comparator bank: scanning downwards leaves the lowest armed match selected
   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_arm_q[i] && (bp_addr_q[i] == pc_wb)) begin
            hit     = 1'b1;
            hit_sel = BP_IW'(i);
         end
      end
   end

   // Breakpoint table write; out-of-range indices are dropped
   always_comb begin
      bp_addr_d = bp_addr_q;
      bp_arm_d  = bp_arm_q;
      if (bp_we && (int'(bp_idx) < NUM_BP)) begin
         bp_addr_d[bp_idx] = bp_addr;
         bp_arm_d[bp_idx]  = bp_arm;
      end
   end

   // RUN/HALTED next state, counters and halt reason; clear overrides all
   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      retire_d   = retire_q;
      stall_d    = stall_q;
      cause_d    = cause_q;
      hit_idx_d  = hit_idx_q;
      run_retire = 1'b0;
      if (clear) begin
         state_d   = RUN;
         cycle_d   = '0;
         retire_d  = '0;
         stall_d   = '0;
         cause_d   = CAUSE_NONE;
         hit_idx_d = '0;
      end else if (state_q == RUN) begin
         if (cycle_q != CNT_MAX) begin
            cycle_d = cycle_q + CNT_ONE;
         end
         if (wb_valid) begin
            run_retire = 1'b1;
            stall_d    = '0;
            if (retire_q != CNT_MAX) begin
               retire_d = retire_q + CNT_ONE;
            end
            if (hit) begin
               state_d   = HALTED;
               cause_d   = CAUSE_BP;
               hit_idx_d = hit_sel;
            end
         end else begin
            stall_d = stall_q + SC_ONE;
            if (stall_d == SC_LIMIT) begin
               state_d   = HALTED;
               cause_d   = CAUSE_STALL;
               hit_idx_d = '0;
            end
         end
      end
   end

   // State, counter and breakpoint registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= RUN;
         cycle_q   <= '0;
         retire_q  <= '0;
         stall_q   <= '0;
         cause_q   <= CAUSE_NONE;
         hit_idx_q <= '0;
         bp_arm_q  <= '0;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cycle_q   <= cycle_d;
         retire_q  <= retire_d;
         stall_q   <= stall_d;
         cause_q   <= cause_d;
         hit_idx_q <= hit_idx_d;
         bp_arm_q  <= bp_arm_d;
         bp_addr_q <= bp_addr_d;
      end
   end

   assign halt       = (state_q == HALTED);
   assign halt_cause = cause_q;
   assign hit_idx    = hit_idx_q;
   assign cycle_cnt  = cycle_q;
   assign retire_cnt = retire_q;
   assign dbg_state  = state_q;

`ifdef PC_TRACE_EN
   pc_trace_buf #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (TRACE_DEPTH)
   ) u_trace (
      .clk       (clk),
      .rstn      (rstn),
      .push      (run_retire),
      .push_data (pc_wb),
      .pop       (trc_rd),
      .rd_data   (trc_data),
      .empty     (trc_empty),
      .count     (trc_count)
   );
`else
   logic unused_trace;
   assign unused_trace = trc_rd ^ run_retire;
   assign trc_data     = '0;
   assign trc_empty    = 1'b1;
   assign trc_count    = '0;
`endif

endmodule
